// File: rtl/addsub_accum_unit.sv
// Signed add/subtract accumulator with optional saturation, overflow counting
// and a valid/ready result port.
//
// state | meaning
// IDLE  | waiting for a command, in_ready high
// EXEC  | captured command is applied to acc and result registers on next edge
// RESP  | result presented with out_valid, held until out_ready
module addsub_accum_unit #(
   parameter int WIDTH    = 4,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_operand_i,
   input  logic             in_sub_i,
   input  logic             in_clear_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_acc_o,
   output logic [WIDTH:0]   out_sum_o,
   output logic             out_ovf_o,
   output logic             out_sat_o,
   output logic [7:0]       ovf_count_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] op_q;
   logic             sub_q;
   logic             clr_q;
   logic [WIDTH:0]   sum_q, sum_d;
   logic             ovf_q, ovf_d;
   logic             sat_q, sat_d;
   logic [7:0]       cnt_q, cnt_d;

   logic [WIDTH:0]   sa, sb, raw_sum;
   logic             raw_ovf;
   logic             accept;

   assign accept = (state_q == ST_IDLE) && in_valid_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid_i)  state_d = ST_EXEC;
         ST_EXEC:                  state_d = ST_RESP;
         ST_RESP: if (out_ready_i) state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // Sign-extending both operands by one bit makes the 5-bit result exact.
   always_comb begin
      sa      = {acc_q[WIDTH-1], acc_q};
      sb      = {op_q[WIDTH-1], op_q};
      raw_sum = sub_q ? (sa - sb) : (sa + sb);
      raw_ovf = raw_sum[WIDTH] ^ raw_sum[WIDTH-1];
   end

   always_comb begin
      acc_d = raw_sum[WIDTH-1:0];
      sum_d = raw_sum;
      ovf_d = raw_ovf;
      sat_d = 1'b0;
      cnt_d = cnt_q;
      if (clr_q) begin
         acc_d = '0;
         sum_d = '0;
         ovf_d = 1'b0;
      end else if (raw_ovf) begin
         if (SATURATE) begin
            acc_d = raw_sum[WIDTH] ? ACC_MIN : ACC_MAX;
            sat_d = 1'b1;
         end
         if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         op_q    <= '0;
         sub_q   <= 1'b0;
         clr_q   <= 1'b0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
         sat_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q  <= in_operand_i;
            sub_q <= in_sub_i;
            clr_q <= in_clear_i;
         end
         if (state_q == ST_EXEC) begin
            acc_q <= acc_d;
            sum_q <= sum_d;
            ovf_q <= ovf_d;
            sat_q <= sat_d;
            cnt_q <= cnt_d;
         end
      end
   end

   assign in_ready_o  = (state_q == ST_IDLE);
   assign out_valid_o = (state_q == ST_RESP);
   assign out_acc_o   = acc_q;
   assign out_sum_o   = sum_q;
   assign out_ovf_o   = ovf_q;
   assign out_sat_o   = sat_q;
   assign ovf_count_o = cnt_q;

endmodule
